rv32m_div_controller: RTL
=========================

// Module: rv32m_div_controller
// PURPOSE
//  Sequencing front end between the RV32M execute stage and the shift-test-restore divider.
//  - Decodes DIV/DIVU/REM/REMU.
//  - Resolves RISC-V special cases (divide-by-zero, signed overflow) without running the divider.
//  - Reuses the last divider result when the same operands repeat (DIV followed by REM).
//  - Otherwise pulses the divider's start, holds its operands stable and registers the selected result.
// PARAMETERS
//  N         32  operand/result width
//  CACHE_EN  1   1 = last-result reuse enabled; 0 = every non-special op runs the divider
// PORTS
//  CLK            in   1  clock
//  nRST           in   1  reset, asynchronous, active-low
//  req_valid      in   1  divide op present in EX; held until done or flush
//  op             in   2  00 DIV, 01 DIVU, 10 REM, 11 REMU
//  rs1            in   N  dividend
//  rs2            in   N  divisor
//  flush          in   1  pipeline kill of current op
//  busy           out  1  stall request to pipeline
//  done           out  1  one-cycle pulse: result valid
//  result         out  N  quotient (DIV/DIVU) or remainder (REM/REMU)
//  div_start      out  1  one-cycle start pulse to divider
//  div_dividend   out  N  registered, stable from START until next start
//  div_divisor    out  N  registered, stable from START until next start
//  div_is_signed  out  1  registered, stable from START until next start
//  div_quotient   in   N  divider quotient
//  div_remainder  in   N  divider remainder
//  div_finished   in   1  divider completion, level
// BEHAVIOUR
//  Reset:
//  - state=IDLE; done, busy, div_start, result, div_* operands = 0; cache_valid=0.
//  States: IDLE, START, WAIT, DONE.
//  IDLE (req_valid sampled only here; signed = ~op[0]):
//  - rs2==0 -> quotient all-ones, remainder rs1; go to DONE.
//  - signed, rs1==1<<(N-1), rs2==all-ones -> quotient rs1, remainder 0; go to DONE.
//  - CACHE_EN, cache_valid, {rs1,rs2,signed} == cache tag -> cached q/r; go to DONE.
//  - else -> latch rs1/rs2/signed into div_* and the op-select bit; go to START.
//  START:
//  - div_start=1 for exactly this cycle; go to WAIT.
//  WAIT:
//  - When div_finished=1: capture q or r into result; write cache tag/q/r with cache_valid=1; go to DONE.
//  - div_finished is not sampled in START (it may still be high from the previous op).
//  DONE:
//  - done=1 for one cycle with result valid; go to IDLE.
//  busy:
//  - = (req_valid & state==IDLE & ~flush) | state in {START, WAIT}.
//  - Deasserts in the DONE cycle so the pipeline advances.
//  Requester:
//  - Must present the next op (or drop req_valid) in the cycle after done.
//  - A still-valid request seen in IDLE is treated as a new op.
//  Latency (request-accept cycle = 0):
//  - special case or cache hit: done in cycle 1.
//  - divider run: done in cycle 2N+4 (68 for N=32).
//  flush:
//  - Any state -> IDLE next cycle; no done pulse; result register unchanged.
//  - A flush in WAIT abandons the divider run: it is left to finish, its output is ignored, the cache is not written.
//  - The next miss reissues div_start (start overrides a running divider).
//  - flush and div_finished in the same cycle: flush wins; no cache write.
//  Cache:
//  - Cleared only by reset; special-case results are never cached.
//  - CACHE_EN=0: cache_valid is held at 0.
//  Async reset mid-operation:
//  - Immediate return to the reset values above; any in-flight op is dropped.
// TESTING
//  1 DIV rs1=20, rs2=0xFFFFFFFD -> one div_start, done at cycle 68, result 0xFFFFFFFA.
//  2 REM, same operands, next op -> no div_start, done at cycle 1, result 0x00000002 (cache hit).
//  3 DIVU rs1=0x1234, rs2=0 -> result 0xFFFFFFFF, cycle 1; REMU same operands -> 0x00001234; no div_start.
//  4 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; both cycle 1, no div_start.
//  5 DIVU 20/3 with flush at cycle 10, then DIVU 100/7 -> no done for the first op; result 14 at cycle 68 after the second accept.
//  6 DIVU 20/0xFFFFFFFD after DIV 20/0xFFFFFFFD -> cache miss (signedness differs), result 0; nRST pulse mid-WAIT -> busy=0, done=0, next repeat op misses.

Source files
------------

// File: rtl/rv32m_div_controller.sv
// RV32M divide sequencer: decodes DIV/DIVU/REM/REMU, resolves special cases,
// reuses the last divider result and drives the shift-test-restore divider.
module rv32m_div_controller #(
   parameter int N        = 32,
   parameter bit CACHE_EN = 1'b1
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         req_valid,
   input  logic [1:0]   op,
   input  logic [N-1:0] rs1,
   input  logic [N-1:0] rs2,
   input  logic         flush,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         div_start,
   output logic [N-1:0] div_dividend,
   output logic [N-1:0] div_divisor,
   output logic         div_is_signed,
   input  logic [N-1:0] div_quotient,
   input  logic [N-1:0] div_remainder,
   input  logic         div_finished
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

   logic [1:0]   state;
   logic         sel_rem;
   logic         cache_valid;
   logic [N-1:0] tag_a;
   logic [N-1:0] tag_b;
   logic         tag_s;
   logic [N-1:0] cache_q;
   logic [N-1:0] cache_r;

   logic is_signed;
   logic div_zero;
   logic ovf;
   logic hit;

   always_comb begin
      is_signed = ~op[0];
      div_zero  = (rs2 == '0);
      ovf       = is_signed & (rs1 == MIN_NEG) & (rs2 == '1);
      hit       = CACHE_EN & cache_valid & (rs1 == tag_a)
                & (rs2 == tag_b) & (is_signed == tag_s);
   end

   assign busy      = (req_valid & (state == IDLE) & ~flush)
                    | (state == START) | (state == WAIT);
   assign done      = (state == DONE) & ~flush;
   assign div_start = (state == START) & ~flush;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state         <= IDLE;
         result        <= '0;
         sel_rem       <= 1'b0;
         div_dividend  <= '0;
         div_divisor   <= '0;
         div_is_signed <= 1'b0;
         cache_valid   <= 1'b0;
         tag_a         <= '0;
         tag_b         <= '0;
         tag_s         <= 1'b0;
         cache_q       <= '0;
         cache_r       <= '0;
      end else if (flush) begin
         // abandoned divider runs are never written to the cache
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (div_zero) begin
                     result <= op[1] ? rs1 : '1;
                     state  <= DONE;
                  end else if (ovf) begin
                     result <= op[1] ? '0 : rs1;
                     state  <= DONE;
                  end else if (hit) begin
                     result <= op[1] ? cache_r : cache_q;
                     state  <= DONE;
                  end else begin
                     div_dividend  <= rs1;
                     div_divisor   <= rs2;
                     div_is_signed <= is_signed;
                     sel_rem       <= op[1];
                     state         <= START;
                  end
               end
            end
            // div_finished may still be high from the last run here
            START: state <= WAIT;
            WAIT: begin
               if (div_finished) begin
                  result      <= sel_rem ? div_remainder : div_quotient;
                  cache_valid <= CACHE_EN;
                  tag_a       <= div_dividend;
                  tag_b       <= div_divisor;
                  tag_s       <= div_is_signed;
                  cache_q     <= div_quotient;
                  cache_r     <= div_remainder;
                  state       <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
